// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset, lock qualification and retry sequencer.
// Optional lock-loss counter output o_loss_cnt is enabled with PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_lock,
  input  logic       i_kick,
  output logic       o_pll_rst,
  output logic       o_rst,
  output logic       o_locked,
  output logic       o_fail,
  output logic [3:0] o_retries
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] o_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  MAX_R       = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        lock_s_q, lock_s_d;
  logic        pll_rst_q, pll_rst_d;
  logic        rst_q, rst_d;
  logic        locked_q, locked_d;
  logic        fail_q, fail_d;
  logic [3:0]  retries_q, retries_d;
  logic [3:0]  retries_inc;
  logic        loss_event;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      rst_q     <= 1'b1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= sync1_d;
      lock_s_q  <= lock_s_d;
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      retries_q <= retries_d;
    end
  end

  always_comb begin
    sync1_d     = i_lock;
    lock_s_d    = sync1_q;
    state_d     = state_q;
    retries_d   = retries_q;
    loss_event  = 1'b0;
    retries_inc = (retries_q == MAX_R) ? retries_q : retries_q + 4'd1;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == MAX_R) ? S_FAIL : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d    = S_PLL_RST;
          loss_event = 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    // A kick overrides whatever transition was computed above, including the loss count.
    if (i_kick) begin
      state_d    = S_PLL_RST;
      retries_d  = '0;
      loss_event = 1'b0;
    end

    if ((state_d != state_q) || i_kick) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAIL);
    rst_d     = (state_d != S_RUN);
    locked_d  = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign o_pll_rst = pll_rst_q;
  assign o_rst     = rst_q;
  assign o_locked  = locked_q;
  assign o_fail    = fail_q;
  assign o_retries = retries_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_event && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) loss_cnt_q <= '0;
    else          loss_cnt_q <= loss_cnt_d;
  end

  assign o_loss_cnt = loss_cnt_q;
`else
  logic unused_loss;
  assign unused_loss = loss_event;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       kick;
  logic       o_pll_rst, o_rst, o_locked, o_fail;
  logic [3:0] o_retries;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] o_loss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_lock   (lock),
    .i_kick   (kick),
    .o_pll_rst(o_pll_rst),
    .o_rst    (o_rst),
    .o_locked (o_locked),
    .o_fail   (o_fail),
    .o_retries(o_retries)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .o_loss_cnt(o_loss_cnt)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_pll_rst, input logic e_rst,
                         input logic e_locked, input logic e_fail, input logic [3:0] e_retries);
    checks++;
    assert (o_pll_rst === e_pll_rst) else begin
      errors++;
      $error("FAIL %s o_pll_rst: observed=%b expected=%b", tag, o_pll_rst, e_pll_rst);
    end
    checks++;
    assert (o_rst === e_rst) else begin
      errors++;
      $error("FAIL %s o_rst: observed=%b expected=%b", tag, o_rst, e_rst);
    end
    checks++;
    assert (o_locked === e_locked) else begin
      errors++;
      $error("FAIL %s o_locked: observed=%b expected=%b", tag, o_locked, e_locked);
    end
    checks++;
    assert (o_fail === e_fail) else begin
      errors++;
      $error("FAIL %s o_fail: observed=%b expected=%b", tag, o_fail, e_fail);
    end
    checks++;
    assert (o_retries === e_retries) else begin
      errors++;
      $error("FAIL %s o_retries: observed=%0d expected=%0d", tag, o_retries, e_retries);
    end
  endtask

`ifdef PLL_SEQ_LOSS_CNT_EN
  task automatic chk_loss(input string tag, input logic [7:0] e_loss);
    checks++;
    assert (o_loss_cnt === e_loss) else begin
      errors++;
      $error("FAIL %s o_loss_cnt: observed=%0d expected=%0d", tag, o_loss_cnt, e_loss);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    lock  = 1'b0;
    kick  = 1'b0;
    tick(2);
    chk_out("reset_held", 1, 1, 0, 0, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk_loss("reset_held", 8'd0);
`endif

    // Release, then a 4-cycle PLL reset.
    rst_n = 1'b1;
    tick(3);
    chk_out("first_rst_last", 1, 1, 0, 0, 0);
    tick(1);
    chk_out("first_wait", 0, 1, 0, 0, 0);

    // Clean lock: i_lock rises 3 cycles after o_pll_rst falls.
    tick(3);
    lock = 1'b1;
    tick(10);
    chk_out("clean_stable_end", 0, 1, 0, 0, 0);
    tick(1);
    chk_out("clean_run", 0, 0, 1, 0, 0);

    // Lock loss in RUN.
    tick(2);
    lock = 1'b0;
    tick(2);
    chk_out("loss_sync_delay", 0, 0, 1, 0, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk_loss("loss_before", 8'd0);
`endif
    tick(1);
    chk_out("loss_pll_rst", 1, 1, 0, 0, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk_loss("loss_after", 8'd1);
`endif

    // Relock with a one-cycle glitch during STABLE cycle 5.
    lock = 1'b1;
    tick(9);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    tick(3);
    chk_out("glitch_no_early_run", 0, 1, 0, 0, 0);
    tick(7);
    chk_out("glitch_window_end", 0, 1, 0, 0, 0);
    tick(1);
    chk_out("glitch_run", 0, 0, 1, 0, 0);

    // Kick from RUN, then no lock: two attempts, then FAIL.
    kick = 1'b1;
    lock = 1'b0;
    tick(1);
    kick = 1'b0;
    chk_out("kick_run", 1, 1, 0, 0, 0);
    tick(3);
    chk_out("nolock_p1_last", 1, 1, 0, 0, 0);
    tick(1);
    chk_out("nolock_w1", 0, 1, 0, 0, 0);
    tick(19);
    chk_out("nolock_w1_last", 0, 1, 0, 0, 0);
    tick(1);
    chk_out("nolock_to1", 1, 1, 0, 0, 1);
    tick(3);
    chk_out("nolock_p2_last", 1, 1, 0, 0, 1);
    tick(1);
    chk_out("nolock_w2", 0, 1, 0, 0, 1);
    tick(19);
    chk_out("nolock_w2_last", 0, 1, 0, 0, 1);
    tick(1);
    chk_out("nolock_fail", 1, 1, 0, 1, 2);
    tick(5);
    chk_out("fail_hold", 1, 1, 0, 1, 2);

    // Kick in FAIL.
    kick = 1'b1;
    tick(1);
    kick = 1'b0;
    chk_out("kick_fail", 1, 1, 0, 0, 0);
    tick(3);
    chk_out("kick_fail_p_last", 1, 1, 0, 0, 0);
    tick(1);
    chk_out("kick_fail_wait", 0, 1, 0, 0, 0);
    tick(19);
    chk_out("kf_w1_last", 0, 1, 0, 0, 0);
    tick(1);
    chk_out("kf_to1", 1, 1, 0, 0, 1);
    tick(3);
    chk_out("kf_p2_last", 1, 1, 0, 0, 1);
    tick(1);
    chk_out("kf_w2", 0, 1, 0, 0, 1);

    // Kick coincident with the timeout that would otherwise enter FAIL.
    tick(19);
    kick = 1'b1;
    tick(1);
    kick = 1'b0;
    chk_out("kick_at_timeout", 1, 1, 0, 0, 0);
    tick(3);
    chk_out("kat_p_last", 1, 1, 0, 0, 0);
    tick(1);
    chk_out("kat_wait", 0, 1, 0, 0, 0);

    // One timeout so retries is nonzero, then reach STABLE and reset asynchronously.
    tick(19);
    chk_out("pre_to_last", 0, 1, 0, 0, 0);
    tick(1);
    chk_out("pre_to", 1, 1, 0, 0, 1);
    lock = 1'b1;
    tick(3);
    chk_out("pre_p_last", 1, 1, 0, 0, 1);
    tick(1);
    chk_out("pre_wait", 0, 1, 0, 0, 1);
    tick(3);
    chk_out("mid_stable", 0, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 1, 1, 0, 0, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk_loss("async_reset", 8'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick(3);
    chk_out("rerst_p_last", 1, 1, 0, 0, 0);
    tick(1);
    chk_out("rerst_wait", 0, 1, 0, 0, 0);
    tick(9);
    chk_out("rerst_run", 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
